// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   DIV_W      - operand / result width (32)
//   CNT_W      - iteration counter width (5)
//   CNT_LAST   - counter value of the last CALC iteration
//   div_state_t- FSM state enumeration (IDLE, CALC, FIX, DONE)
//   f_mag      - two's-complement magnitude (|-2^31| = 0x80000000 unsigned)
//   f_cond_neg - conditional two's-complement negation
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitude of a signed value; the most negative value maps onto itself,
    // which read as unsigned is exactly 2^31.
    function automatic logic [DIV_W-1:0] f_mag(input logic [DIV_W-1:0] v);
        f_mag = v[DIV_W-1] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] f_cond_neg(input logic [DIV_W-1:0] v,
                                                     input logic           neg);
        f_cond_neg = neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// -----------------------------------------------------------------------------
// div_nr_step
// One combinational radix-2 non-restoring division iteration.
//   i_rem  [DIV_W:0]   - signed partial remainder (one guard bit)
//   i_quo  [DIV_W-1:0] - dividend bits still to shift in / quotient bits so far
//   i_dmag [DIV_W-1:0] - divisor magnitude
//   o_rem  [DIV_W:0]   - next partial remainder
//   o_quo  [DIV_W-1:0] - next quotient/dividend shift register
// -----------------------------------------------------------------------------
module div_nr_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   i_rem,
    input  logic [DIV_W-1:0] i_quo,
    input  logic [DIV_W-1:0] i_dmag,
    output logic [DIV_W:0]   o_rem,
    output logic [DIV_W-1:0] o_quo
);

    logic [DIV_W:0] w_rem_sh;
    logic [DIV_W:0] w_dext;

    assign w_rem_sh = {i_rem[DIV_W-1:0], i_quo[DIV_W-1]};
    assign w_dext   = {1'b0, i_dmag};

    // A negative remainder is repaired lazily by adding on the next step
    // instead of restoring; the quotient bit is 1 when the result is >= 0.
    assign o_rem = i_rem[DIV_W] ? (w_rem_sh + w_dext) : (w_rem_sh - w_dext);
    assign o_quo = {i_quo[DIV_W-2:0], ~o_rem[DIV_W]};

endmodule

// File: rtl/signed_divider_32bit_seq.sv
// -----------------------------------------------------------------------------
// signed_divider_32bit_seq
// Sequential 32-bit signed divider (truncation toward zero), one
// non-restoring iteration per cycle, valid/ready on both sides.
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready - operand handshake (in_ready only in IDLE)
//   dividend, divisor   - signed two's-complement operands
//   out_valid/out_ready - result handshake
//   quotient_o, remainder_o, div_by_zero_o - result, held stable in DONE
// Divide by zero gives quotient 0xFFFFFFFF and remainder = dividend;
// 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
// Optional macro DIV_BYPASS_EN: those special operands jump from IDLE
// straight to FIX (result 2 cycles after the handshake instead of 34).
// -----------------------------------------------------------------------------
module signed_divider_32bit_seq
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIV_W-1:0] quotient_o,
    output logic [DIV_W-1:0] remainder_o,
    output logic             div_by_zero_o
);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W:0]   r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_dmag;
    logic [DIV_W-1:0] r_dividend;
    logic             r_sd;
    logic             r_dz;
    logic             r_ovf;
    logic             r_out_valid;
    logic [DIV_W-1:0] r_q_out;
    logic [DIV_W-1:0] r_r_out;
    logic             r_dz_out;

    logic [DIV_W:0]   w_step_rem;
    logic [DIV_W-1:0] w_step_quo;
    logic             w_in_dz;
    logic             w_in_ovf;
    logic             w_bypass;
    logic [DIV_W-1:0] w_rem_lo;
    logic [DIV_W-1:0] w_q_fix;
    logic [DIV_W-1:0] w_r_fix;
    logic             w_dz_fix;

    assign w_in_dz  = (divisor == 32'h0000_0000);
    assign w_in_ovf = (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

`ifdef DIV_BYPASS_EN
    assign w_bypass = w_in_dz | w_in_ovf;
`else
    assign w_bypass = 1'b0;
`endif

    div_nr_step u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dmag (r_dmag),
        .o_rem  (w_step_rem),
        .o_quo  (w_step_quo)
    );

    // Next-state logic of the IDLE/CALC/FIX/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_bypass ? FIX : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Final correction and sign application. The corrected remainder is
    // below the divisor magnitude, so the low 32 bits hold it exactly.
    always_comb begin
        w_rem_lo = r_rem[DIV_W] ? (r_rem[DIV_W-1:0] + r_dmag) : r_rem[DIV_W-1:0];
        if (r_dz) begin
            w_q_fix  = 32'hFFFF_FFFF;
            w_r_fix  = r_dividend;
            w_dz_fix = 1'b1;
        end else if (r_ovf) begin
            w_q_fix  = 32'h8000_0000;
            w_r_fix  = 32'h0000_0000;
            w_dz_fix = 1'b0;
        end else begin
            w_q_fix  = f_cond_neg(r_quo, r_dividend[DIV_W-1] ^ r_sd);
            w_r_fix  = f_cond_neg(w_rem_lo, r_dividend[DIV_W-1]);
            w_dz_fix = 1'b0;
        end
    end

    // State register, operand capture and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 5'd0;
            r_rem      <= 33'd0;
            r_quo      <= 32'd0;
            r_dmag     <= 32'd0;
            r_dividend <= 32'd0;
            r_sd       <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt      <= 5'd0;
                        r_rem      <= 33'd0;
                        r_quo      <= f_mag(dividend);
                        r_dmag     <= f_mag(divisor);
                        r_dividend <= dividend;
                        r_sd       <= divisor[DIV_W-1];
                        r_dz       <= w_in_dz;
                        r_ovf      <= w_in_ovf;
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded in FIX, held through DONE until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_q_out     <= 32'd0;
            r_r_out     <= 32'd0;
            r_dz_out    <= 1'b0;
        end else begin
            case (r_state)
                FIX: begin
                    r_out_valid <= 1'b1;
                    r_q_out     <= w_q_fix;
                    r_r_out     <= w_r_fix;
                    r_dz_out    <= w_dz_fix;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = r_out_valid;
    assign quotient_o    = r_q_out;
    assign remainder_o   = r_r_out;
    assign div_by_zero_o = r_dz_out;

endmodule

// File: tb/tb_signed_divider_32bit_seq.sv
// -----------------------------------------------------------------------------
// tb_signed_divider_32bit_seq
// Scoreboard bench: the stimulus side pushes hand-computed expected results,
// a negedge monitor pops one entry per rising out_valid and compares
// quotient, remainder, divide-by-zero flag and latency.
// -----------------------------------------------------------------------------
module tb_signed_divider_32bit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    signed_divider_32bit_seq dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend      (dividend),
        .divisor       (divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

`ifdef DIV_BYPASS_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif
    localparam int LAT_N = 34;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          hs;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rising out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out_valid: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient_o, e.q);
                    check("remainder", remainder_o, e.r);
                    check("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, e.dz});
                    check("latency", cyc - e.hs + 1, e.lat);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end else begin
            dividend = a;
            divisor  = b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.hs = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    logic [31:0] va [13] = '{32'h0000_0064, 32'hFFFF_FF9C, 32'h0000_0007, 32'h8000_0000,
                             32'h0000_0064, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'h8000_0000,
                             32'hFFFF_FFFF};
    logic [31:0] vb [13] = '{32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0005,
                             32'h0000_0001, 32'h0000_0002, 32'h8000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF};
    logic [31:0] vq [13] = '{32'h0000_000E, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFF2, 32'h0000_000E, 32'hFFFF_FFFF, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'hC000_0000, 32'h0000_0000, 32'h0000_0001,
                             32'h0000_0000};
    logic [31:0] vr [13] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000,
                             32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h0000_0000,
                             32'h0000_0000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000,
                             32'hFFFF_FFFF};
    logic        vdz [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vsp [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", quotient_o, 32'd0);
        check("rst_remainder", remainder_o, 32'd0);
        check("rst_dz", {31'd0, div_by_zero_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            send(va[i], vb[i], vq[i], vr[i], vdz[i], vsp[i] ? LAT_SP : LAT_N);
            drain();
        end

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_N);
        for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_quotient", quotient_o, 32'd14);
            check("hold_remainder", remainder_o, 32'd2);
            check("hold_dz", {31'd0, div_by_zero_o}, 32'd0);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a division aborts it.
        send(32'd500, 32'd5, 32'd100, 32'd0, 1'b0, LAT_N);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", {31'd0, seen}, 32'd0);
        send(32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 32'd1, 1'b0, LAT_N);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_divider_32bit_seq.md
SIGNED_DIVIDER_32BIT_SEQ -- requirements
Module: signed_divider_32bit_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: dividend/divisor present.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have port dividend, input, 32 bits: signed two's-complement dividend.
REQ-006 SHALL have port divisor, input, 32 bits: signed two's-complement divisor.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-009 SHALL have port quotient_o, output, 32 bits: signed quotient.
REQ-010 SHALL have port remainder_o, output, 32 bits: signed remainder.
REQ-011 SHALL have port div_by_zero_o, output, 1 bit: flag for the current result, valid with out_valid.

Function
REQ-012 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL capture operands on the edge where in_valid && in_ready, then enter CALC.
REQ-015 SHALL register operand signs and 32-bit magnitudes at capture; |-2^31| SHALL be 0x80000000 unsigned.
REQ-016 SHALL run one radix-2 non-restoring iteration per CALC cycle for exactly 32 cycles, counted by a 5-bit counter.
REQ-017 SHALL leave CALC when the counter wraps from 31, then spend one FIX cycle.
REQ-018 FIX SHALL add the divisor magnitude back if the partial remainder is negative, then apply signs: quotient negated iff operand signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-019 SHALL enter DONE after FIX and assert out_valid there; with handshake at edge 0, out_valid SHALL be high from cycle 34.
REQ-020 SHALL hold quotient_o, remainder_o, div_by_zero_o and out_valid stable in DONE while out_ready is low.
REQ-021 SHALL return to IDLE on the edge where out_valid && out_ready; a new operand handshake SHALL be possible on the next cycle.
REQ-022 SHALL handle divisor 0 as quotient 0xFFFFFFFF, remainder = dividend, div_by_zero_o=1.
REQ-023 SHALL handle overflow (0x80000000 / 0xFFFFFFFF) as quotient 0x80000000, remainder 0, div_by_zero_o=0.
REQ-024 SHALL ignore in_valid outside IDLE; no operands are queued.

Reset
REQ-025 SHALL, on rst, force state IDLE, counter 0, in_ready=1 after reset release, out_valid=0, quotient_o=0, remainder_o=0, div_by_zero_o=0.
REQ-026 SHALL abort an in-flight division when rst is asserted mid-operation; no out_valid SHALL follow for that operation.

Configuration
REQ-027 SHALL, when DIV_BYPASS_EN is defined, resolve divide-by-zero and overflow operands directly from IDLE to FIX, skipping CALC, so out_valid is high at cycle 2.
REQ-028 SHALL, without DIV_BYPASS_EN, run all special cases through the full 32 CALC cycles with the REQ-022/023 results and the same 34-cycle latency.

Structure
REQ-029 SHALL take the width constant (32), the counter width (5) and the FSM state enumeration from shared package div_pkg.
REQ-030 SHALL put one combinational non-restoring iteration (shift, add/subtract, quotient bit) in sub-module div_nr_step, instantiated once.

Verification
REQ-031 SHALL cover 100 / 7 -> quotient 14, remainder 2, out_valid at cycle 34.
REQ-032 SHALL cover -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFFFFFE).
REQ-033 SHALL cover 7 / 0 -> quotient 0xFFFFFFFF, remainder 7, div_by_zero_o=1, out_valid at cycle 2 with DIV_BYPASS_EN and cycle 34 without.
REQ-034 SHALL cover 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 SHALL cover out_ready held low 10 cycles after result -> outputs stable; in_ready=0 until the output handshake, then 1 the next cycle.
REQ-036 SHALL cover rst pulsed at cycle 15 of a division -> IDLE, in_ready=1 after release, no out_valid for the aborted operation; the next 1000 / -3 SHALL give quotient -333, remainder 1.
